// File: rtl/pwq_pkg.sv
// rtl/pwq_pkg.sv - shared types, constants and address helper for pixel_write_queue
package pwq_pkg;

    localparam int         H_RES_DEF  = 640;
    localparam int         V_RES_DEF  = 480;
    localparam logic [3:0] BYTE_EN    = 4'b0011;

    // A 640x480 bitmap needs 19 address bits; wider bridge addresses are zero-extended.
    localparam int         PIX_ADDR_W = 19;

    typedef struct packed {
        logic [PIX_ADDR_W-1:0] addr;
        logic [7:0]            intensity;
    } pwq_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } pwq_state_e;

    // Linear bitmap address y*h_res + x, truncated to PIX_ADDR_W bits.
    // The 640-wide case uses two shifts instead of a multiplier (640 = 512 + 128).
    function automatic logic [PIX_ADDR_W-1:0] pwq_pix_addr(input logic [9:0] x,
                                                            input logic [9:0] y,
                                                            input int         h_res);
        logic [PIX_ADDR_W-1:0] x_w;
        logic [PIX_ADDR_W-1:0] y_w;
        x_w = PIX_ADDR_W'(x);
        y_w = PIX_ADDR_W'(y);
        if (h_res == H_RES_DEF)
            return (y_w << 9) + (y_w << 7) + x_w;
        return (y_w * PIX_ADDR_W'(h_res)) + x_w;
    endfunction

endpackage

// File: rtl/pwq_fifo.sv
// rtl/pwq_fifo.sv - synchronous FIFO of pwq_entry_t with flush and registered full
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i, wdata_i   write request and entry (ignored when full or flushing)
//   pop_i, rdata_o    read request and head entry (pop ignored when empty or flushing)
//   flush_i           discard all stored entries this cycle, including a same-cycle push
//   full_o, empty_o   status; full_o is a register
//   count_o           number of stored entries
module pwq_fifo
    import pwq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  pwq_entry_t             wdata_i,
    input  logic                   pop_i,
    output pwq_entry_t             rdata_o,
    input  logic                   flush_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pwq_entry_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full_q;
    logic          push_ok;
    logic          pop_ok;

    // full_q is a register, so a pop in the same cycle never opens a slot for a push.
    assign push_ok = push_i & ~full_q & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;
    assign empty_o = (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok)
            count_d = count_q + CW'(1);
        else if (pop_ok && !push_ok)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

    // Storage is not reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign count_o = count_q;

endmodule

// File: rtl/pixel_write_queue.sv
// rtl/pixel_write_queue.sv - queues fractal pixels and issues acknowledged SDRAM bridge writes
//
// Ports:
//   CLK, RESET                      clock, synchronous active-high reset
//   in_valid/in_ready               pixel handshake; in_x, in_y, in_intensity carry the pixel
//   flush                           drop all queued, not-yet-issued pixels
//   sdram_write, sdram_addr,
//   sdram_write_data,
//   sdram_byte_enable               bridge write request, held until sdram_ack
//   sdram_ack                       one-cycle pulse retiring the current write
//   queue_count                     FIFO occupancy, excluding the write being issued
//   drop_count                      out-of-range pixels discarded (saturating)
//
// Build option: PWQ_RANGE_CHECK_EN drops pixels outside H_RES x V_RES and counts them;
// without it every pixel is written and drop_count is 0.
module pixel_write_queue
    import pwq_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int ADDR_W = 23
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   in_valid,
    input  logic [9:0]             in_x,
    input  logic [9:0]             in_y,
    input  logic [7:0]             in_intensity,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   sdram_write,
    output logic [ADDR_W-1:0]      sdram_addr,
    output logic [7:0]             sdram_write_data,
    output logic [3:0]             sdram_byte_enable,
    input  logic                   sdram_ack,
    output logic [$clog2(DEPTH):0] queue_count,
    output logic [15:0]            drop_count
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ADDR_W < PIX_ADDR_W ||
        H_RES * V_RES > (1 << PIX_ADDR_W)) begin : g_param_check
        $error("pixel_write_queue: unsupported DEPTH, ADDR_W or resolution");
    end

    pwq_entry_t            push_entry;
    pwq_entry_t            head_entry;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  accept;
    logic                  in_range;
    logic                  push;
    logic                  pop;

    pwq_state_e            state_q;
    logic                  write_q;
    logic [PIX_ADDR_W-1:0] addr_q;
    logic [7:0]            data_q;

    assign in_ready = ~fifo_full;
    assign accept   = in_valid & in_ready;

    assign push_entry.addr      = pwq_pix_addr(in_x, in_y, H_RES);
    assign push_entry.intensity = in_intensity;

`ifdef PWQ_RANGE_CHECK_EN
    localparam logic [10:0] H_LIM = 11'(H_RES);
    localparam logic [10:0] V_LIM = 11'(V_RES);

    logic [15:0] drop_q;
    logic [15:0] drop_d;

    assign in_range = ({1'b0, in_x} < H_LIM) && ({1'b0, in_y} < V_LIM);

    // Rejected pixels still complete the handshake; only the count records them.
    always_comb begin
        drop_d = drop_q;
        if (accept && !in_range && drop_q != 16'hFFFF)
            drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            drop_q <= '0;
        else
            drop_q <= drop_d;
    end

    assign drop_count = drop_q;
`else
    assign in_range   = 1'b1;
    assign drop_count = '0;
`endif

    assign push = accept & in_range;

    // Head is consumed when idle, or when the current write retires. A flush
    // empties the queue, so nothing is popped in that cycle.
    assign pop = ~fifo_empty & ~flush &
                 ((state_q == IDLE) | ((state_q == ISSUE) & sdram_ack));

    pwq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .flush_i (flush),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (queue_count)
    );

    // Write FSM: output registers load on every pop, so back-to-back acks keep
    // sdram_write high with no idle gap between writes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        addr_q  <= head_entry.addr;
                        data_q  <= head_entry.intensity;
                        write_q <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sdram_ack) begin
                        if (pop) begin
                            addr_q <= head_entry.addr;
                            data_q <= head_entry.intensity;
                        end else begin
                            write_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    write_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sdram_write       = write_q;
    assign sdram_addr        = ADDR_W'(addr_q);
    assign sdram_write_data  = data_q;
    assign sdram_byte_enable = BYTE_EN;

endmodule

// File: tb/tb_pixel_write_queue.sv
// tb/tb_pixel_write_queue.sv - self-checking bench for pixel_write_queue
module tb_pixel_write_queue;

    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        in_valid;
    logic [9:0]  in_x;
    logic [9:0]  in_y;
    logic [7:0]  in_intensity;
    logic        in_ready;
    logic        flush;
    logic        sdram_write;
    logic [22:0] sdram_addr;
    logic [7:0]  sdram_write_data;
    logic [3:0]  sdram_byte_enable;
    logic        sdram_ack;
    logic [4:0]  queue_count;
    logic [15:0] drop_count;

    int          total = 0;
    int          bad = 0;
    int          acc = 0;
    int          exp_drop = 0;
    int          gaps;
    logic [30:0] exp_q[$];
    logic [30:0] got_q[$];
    int          px[20];
    int          py[20];
    int          pv[20];

    pixel_write_queue #(
        .DEPTH  (DEPTH),
        .H_RES  (640),
        .V_RES  (480),
        .ADDR_W (23)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .in_valid          (in_valid),
        .in_x              (in_x),
        .in_y              (in_y),
        .in_intensity      (in_intensity),
        .in_ready          (in_ready),
        .flush             (flush),
        .sdram_write       (sdram_write),
        .sdram_addr        (sdram_addr),
        .sdram_write_data  (sdram_write_data),
        .sdram_byte_enable (sdram_byte_enable),
        .sdram_ack         (sdram_ack),
        .queue_count       (queue_count),
        .drop_count        (drop_count)
    );

    always #5 CLK = ~CLK;

    // Every retired write (request high while ack pulses) in the order the bridge sees it.
    always @(posedge CLK) begin
        if (!RESET && sdram_write && sdram_ack)
            got_q.push_back({sdram_addr, sdram_write_data});
    end

    function automatic bit model_in_range(input int x, input int y);
`ifdef PWQ_RANGE_CHECK_EN
        return (x < 640) && (y < 480);
`else
        return 1'b1;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, update the reference model for an accepted pixel,
    // then advance to 1 time unit after the next rising edge.
    task automatic drive(input bit v, input int x, input int y, input int i,
                         input bit ack, input bit fl);
        int a;
        in_valid     = v;
        in_x         = 10'(x);
        in_y         = 10'(y);
        in_intensity = 8'(i);
        sdram_ack    = ack;
        flush        = fl;
        if (v && in_ready) begin
            acc++;
            if (!model_in_range(x, y)) begin
                if (exp_drop < 65535)
                    exp_drop++;
            end else if (!fl) begin
                a = (y * 640 + x) % (1 << 19);
                exp_q.push_back({23'(a), 8'(i)});
            end
        end
        @(posedge CLK);
        #1;
        in_valid  = 1'b0;
        sdram_ack = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic idle(input bit ack);
        drive(1'b0, 0, 0, 0, ack, 1'b0);
    endtask

    task automatic push_rand(input bit ack);
        drive(1'b1, int'($urandom_range(639)), int'($urandom_range(479)),
              int'($urandom_range(255)), ack, 1'b0);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int c = 0; c < budget && got_q.size() < exp_q.size(); c++)
            idle(1'b1);
        check({tag, "_drain_done"}, 32'(got_q.size() >= exp_q.size()), 32'd1);
    endtask

    task automatic compare_phase(input string tag);
        int n;
        check({tag, "_num_writes"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++)
            check($sformatf("%s_write%0d", tag, k), 32'(got_q[k]), 32'(exp_q[k]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        RESET        = 1'b1;
        in_valid     = 1'b0;
        in_x         = '0;
        in_y         = '0;
        in_intensity = '0;
        flush        = 1'b0;
        sdram_ack    = 1'b0;
        repeat (3) @(posedge CLK);
        #1;

        // Reset values
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_write", 32'(sdram_write), 32'd0);
        check("rst_addr", 32'(sdram_addr), 32'd0);
        check("rst_data", 32'(sdram_write_data), 32'd0);
        check("rst_count", 32'(queue_count), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("byte_enable", 32'(sdram_byte_enable), 32'h3);
        RESET = 1'b0;
        idle(1'b0);

        // Single pixel (5,2,0x80): two-edge latency, held until ack
        drive(1'b1, 5, 2, 'h80, 1'b0, 1'b0);
        check("single_count_after_push", 32'(queue_count), 32'd1);
        check("single_write_not_yet", 32'(sdram_write), 32'd0);
        idle(1'b0);
        check("single_write", 32'(sdram_write), 32'd1);
        check("single_count_issuing", 32'(queue_count), 32'd0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("single_addr_c%0d", c), 32'(sdram_addr), 32'd1285);
            check($sformatf("single_data_c%0d", c), 32'(sdram_write_data), 32'h80);
            check($sformatf("single_hold_c%0d", c), 32'(sdram_write), 32'd1);
            if (c < 2)
                idle(1'b0);
        end
        idle(1'b1);
        check("single_write_drop", 32'(sdram_write), 32'd0);
        check("single_count_end", 32'(queue_count), 32'd0);
        compare_phase("single");

        // Burst of 20 with ack low: 16 queued + 1 issuing, then gap-free drain
        for (int k = 0; k < 20; k++) begin
            px[k] = int'($urandom_range(639));
            py[k] = int'($urandom_range(479));
            pv[k] = int'($urandom_range(255));
        end
        acc = 0;
        for (int c = 0; c < 40 && acc < 20 && in_ready; c++)
            drive(1'b1, px[acc], py[acc], pv[acc], 1'b0, 1'b0);
        check("burst_accepted_at_full", 32'(acc), 32'd17);
        check("burst_in_ready_low", 32'(in_ready), 32'd0);
        check("burst_count_full", 32'(queue_count), 32'd16);
        // At full, a same-cycle pop must not admit the offered pixel
        drive(1'b1, px[acc], py[acc], pv[acc], 1'b1, 1'b0);
        check("full_pop_no_push_count", 32'(queue_count), 32'd15);
        check("full_pop_in_ready", 32'(in_ready), 32'd1);
        gaps = 0;
        for (int c = 0; c < 100 && got_q.size() < 20; c++) begin
            if (!sdram_write)
                gaps++;
            if (acc < 20)
                drive(1'b1, px[acc], py[acc], pv[acc], 1'b1, 1'b0);
            else
                idle(1'b1);
        end
        check("burst_no_gaps", 32'(gaps), 32'd0);
        check("burst_write_end", 32'(sdram_write), 32'd0);
        compare_phase("burst");

        // Push and pop in the same cycle at count 4
        repeat (5) push_rand(1'b0);
        check("pp_count_before", 32'(queue_count), 32'd4);
        push_rand(1'b1);
        check("pp_count_after", 32'(queue_count), 32'd4);
        drain("pp", 100);
        check("pp_count_end", 32'(queue_count), 32'd0);
        compare_phase("pp");

        // Flush with 6 queued and one in flight; a same-cycle push is discarded too
        repeat (7) push_rand(1'b0);
        check("flush_count_before", 32'(queue_count), 32'd6);
        drive(1'b1, 10, 10, 'h55, 1'b0, 1'b1);
        check("flush_count_after", 32'(queue_count), 32'd0);
        check("flush_inflight_held", 32'(sdram_write), 32'd1);
        // Only the oldest pixel (already in flight) survives the flush
        while (exp_q.size() > 1)
            void'(exp_q.pop_back());
        repeat (6) idle(1'b1);
        check("flush_write_end", 32'(sdram_write), 32'd0);
        check("flush_count_end", 32'(queue_count), 32'd0);
        compare_phase("flush");

        // Range handling: (640,0) then (639,479)
        drive(1'b1, 640, 0, 'h11, 1'b0, 1'b0);
        drive(1'b1, 639, 479, 'h22, 1'b0, 1'b0);
        drain("range", 50);
        idle(1'b0);
        check("range_drop_count", 32'(drop_count), 32'(exp_drop));
        compare_phase("range");

        // Random traffic with random acks
        for (int c = 0; c < 300; c++)
            drive(1'($urandom_range(1)), int'($urandom_range(639)), int'($urandom_range(479)),
                  int'($urandom_range(255)), ($urandom_range(2) == 0), 1'b0);
        drain("rand", 300);
        check("rand_count_end", 32'(queue_count), 32'd0);
        compare_phase("rand");

        // Reset in ISSUE with 3 queued: everything returns to reset values
        repeat (4) push_rand(1'b0);
        check("midrst_count_before", 32'(queue_count), 32'd3);
        check("midrst_write_before", 32'(sdram_write), 32'd1);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_write", 32'(sdram_write), 32'd0);
        check("midrst_addr", 32'(sdram_addr), 32'd0);
        check("midrst_data", 32'(sdram_write_data), 32'd0);
        check("midrst_count", 32'(queue_count), 32'd0);
        check("midrst_drop", 32'(drop_count), 32'd0);
        RESET = 1'b0;
        exp_drop = 0;
        repeat (4) idle(1'b1);
        check("midrst_no_write_after", 32'(sdram_write), 32'd0);
        check("midrst_no_retired", 32'(got_q.size()), 32'd0);
        got_q.delete();
        exp_q.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
